// File: rtl/writeback_pipe_if.sv
// Execute-side / register-file-side bundle for writeback_pipe: result packets,
// flush, forwarding queries and the two retire buses.
interface writeback_pipe_if #(
  parameter int NQ_EP = 3,
  parameter int NQ_OP = 2
);
  logic [0:142]            ep_in;
  logic [0:142]            op_in;
  logic                    flush;
  logic [NQ_EP-1:0][6:0]   ep_q_addr;
  logic [NQ_OP-1:0][6:0]   op_q_addr;
  logic [NQ_EP-1:0]        ep_q_hit;
  logic [NQ_EP-1:0]        ep_q_haz;
  logic [NQ_EP-1:0][127:0] ep_q_val;
  logic [NQ_OP-1:0]        op_q_hit;
  logic [NQ_OP-1:0]        op_q_haz;
  logic [NQ_OP-1:0][127:0] op_q_val;
  logic [0:142]            wrt_back_arr_ep;
  logic [0:142]            wrt_back_arr_op;

  modport master (
    output ep_in, op_in, flush, ep_q_addr, op_q_addr,
    input  ep_q_hit, ep_q_haz, ep_q_val, op_q_hit, op_q_haz, op_q_val,
           wrt_back_arr_ep, wrt_back_arr_op
  );

  modport slave (
    input  ep_in, op_in, flush, ep_q_addr, op_q_addr,
    output ep_q_hit, ep_q_haz, ep_q_val, op_q_hit, op_q_haz, op_q_val,
           wrt_back_arr_ep, wrt_back_arr_op
  );
endinterface

// File: rtl/writeback_pipe.sv
// Even/odd result shift pipes with fixed-stage retire, same-RT collision
// resolution and newest-wins operand forwarding with a not-ready hazard flag.
module writeback_pipe #(
  parameter int DEPTH = 7,
  parameter int NQ_EP = 3,
  parameter int NQ_OP = 2
) (
  input  logic             clock,
  input  logic             reset,
  writeback_pipe_if.slave  bus
);
  localparam int NQ = NQ_EP + NQ_OP;

  // Packet layout, MSB-first: [0:2] unit, [3:130] result, [131] wr_en,
  // [132:138] RT, [139:142] latency.
  typedef logic [0:142] pkt_t;

  typedef struct packed {
    logic         hit;
    logic         haz;
    logic [127:0] val;
  } fwd_rsp_t;

  pkt_t ep_q [1:DEPTH];
  pkt_t op_q [1:DEPTH];
  pkt_t ep_d [1:DEPTH];
  pkt_t op_d [1:DEPTH];
  pkt_t wb_ep_q, wb_op_q, wb_ep_d, wb_op_d;

  function automatic int leff(input logic [3:0] l);
    if (l == 4'd0)                return 1;
    if (int'({28'd0, l}) > DEPTH) return DEPTH;
    return int'({28'd0, l});
  endfunction

  always_comb begin
    ep_d[1]      = bus.ep_in;
    op_d[1]      = bus.op_in;
    ep_d[1][131] = bus.ep_in[131] & ~bus.flush;
    op_d[1][131] = bus.op_in[131] & ~bus.flush;
    for (int s = 2; s <= DEPTH; s++) begin
      ep_d[s] = ep_q[s-1];
      op_d[s] = op_q[s-1];
    end
    // Flush kills the youngest registered packets; older stages retire normally.
    ep_d[2][131] = ep_q[1][131] & ~bus.flush;
    op_d[2][131] = op_q[1][131] & ~bus.flush;
    wb_ep_d = ep_q[DEPTH];
    wb_op_d = op_q[DEPTH];
    if (ep_q[DEPTH][131] && op_q[DEPTH][131] &&
        ep_q[DEPTH][132:138] == op_q[DEPTH][132:138])
      wb_ep_d[131] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 1; s <= DEPTH; s++) begin
        ep_q[s] <= '0;
        op_q[s] <= '0;
      end
      wb_ep_q <= '0;
      wb_op_q <= '0;
    end else begin
      for (int s = 1; s <= DEPTH; s++) begin
        ep_q[s] <= ep_d[s];
        op_q[s] <= op_d[s];
      end
      wb_ep_q <= wb_ep_d;
      wb_op_q <= wb_op_d;
    end
  end

  assign bus.wrt_back_arr_ep = wb_ep_q;
  assign bus.wrt_back_arr_op = wb_op_q;

  // Even query ports occupy the low lanes, odd ports follow.
  logic [NQ-1:0][6:0] q_addr;
  fwd_rsp_t           rsp [NQ];

  assign q_addr = {bus.op_q_addr, bus.ep_q_addr};

  for (genvar q = 0; q < NQ; q++) begin : g_fwd
    logic         found, rdy;
    logic [127:0] v;
    // Scan oldest to newest so the last match is the newest; odd after even
    // at the same stage so odd wins the tie.
    always_comb begin
      found = 1'b0;
      rdy   = 1'b0;
      v     = '0;
      for (int s = DEPTH; s >= 1; s--) begin
        if (ep_q[s][131] && ep_q[s][132:138] == q_addr[q]) begin
          found = 1'b1;
          rdy   = (s >= leff(ep_q[s][139:142]));
          v     = ep_q[s][3:130];
        end
        if (op_q[s][131] && op_q[s][132:138] == q_addr[q]) begin
          found = 1'b1;
          rdy   = (s >= leff(op_q[s][139:142]));
          v     = op_q[s][3:130];
        end
      end
      rsp[q].hit = found & rdy;
      rsp[q].haz = found & ~rdy;
      rsp[q].val = (found & rdy) ? v : '0;
    end
  end

  for (genvar i = 0; i < NQ_EP; i++) begin : g_ep_out
    assign bus.ep_q_hit[i] = rsp[i].hit;
    assign bus.ep_q_haz[i] = rsp[i].haz;
    assign bus.ep_q_val[i] = rsp[i].val;
  end

  for (genvar i = 0; i < NQ_OP; i++) begin : g_op_out
    assign bus.op_q_hit[i] = rsp[NQ_EP+i].hit;
    assign bus.op_q_haz[i] = rsp[NQ_EP+i].haz;
    assign bus.op_q_val[i] = rsp[NQ_EP+i].val;
  end
endmodule

// File: tb/tb_writeback_pipe.sv
// Scoreboard bench for writeback_pipe: a packet-history model predicts retire
// buses and forwarding results under directed and random traffic.
module tb_writeback_pipe;
  localparam int DEPTH = 7;
  localparam int NQ_EP = 3;
  localparam int NQ_OP = 2;
  localparam int NH    = 4096;

  typedef logic [0:142] pkt_t;
  typedef struct {
    int   edge_n;
    pkt_t ep;
    pkt_t op;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  writeback_pipe_if #(.NQ_EP(NQ_EP), .NQ_OP(NQ_OP)) bif();
  writeback_pipe #(.DEPTH(DEPTH), .NQ_EP(NQ_EP), .NQ_OP(NQ_OP)) dut (
    .clock(clock), .reset(reset), .bus(bif)
  );

  // h_xx[c] = packet captured into stage 1 at edge c, with flush kills applied.
  pkt_t h_ep [NH];
  pkt_t h_op [NH];
  exp_t sb [$];
  int   ecnt   = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [142:0] got, input logic [142:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, ecnt, got, exp);
    end
  endtask

  function automatic pkt_t mk(input bit wr, input int rt, input logic [127:0] res, input int l);
    pkt_t p;
    p          = '0;
    p[0:2]     = 3'($urandom_range(0, 7));
    p[3:130]   = res;
    p[131]     = wr;
    p[132:138] = 7'(rt);
    p[139:142] = 4'(l);
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    return mk($urandom_range(0, 3) != 0, $urandom_range(0, 7),
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 15));
  endfunction

  function automatic int leff(input logic [3:0] l);
    int lv;
    lv = int'(l);
    if (lv == 0)     return 1;
    if (lv > DEPTH)  return DEPTH;
    return lv;
  endfunction

  // Newest registered packet writing addr a decides the answer.
  task automatic model_fwd(input logic [6:0] a, output logic hit, output logic haz,
                           output logic [127:0] val);
    pkt_t p;
    int   s;
    hit = 1'b0; haz = 1'b0; val = '0;
    for (int c = ecnt; c >= 1 && c > ecnt - DEPTH; c--) begin
      s = ecnt - c + 1;
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? h_op[c] : h_ep[c];
        if (p[131] && p[132:138] == a) begin
          if (s >= leff(p[139:142])) begin
            hit = 1'b1;
            val = p[3:130];
          end else begin
            haz = 1'b1;
          end
          return;
        end
      end
    end
  endtask

  task automatic finalize(input int c);
    exp_t e;
    e.edge_n = c + DEPTH;
    e.ep     = h_ep[c];
    e.op     = h_op[c];
    if (e.ep[131] && e.op[131] && e.ep[132:138] == e.op[132:138]) e.ep[131] = 1'b0;
    sb.push_back(e);
  endtask

  // Called at a falling edge; the packets are captured at the next rising edge.
  task automatic step(input pkt_t ep, input pkt_t op, input bit fl);
    int c;
    c = ecnt + 1;
    bif.ep_in = ep;
    bif.op_in = op;
    bif.flush = fl;
    if (fl) begin
      ep[131] = 1'b0;
      op[131] = 1'b0;
      h_ep[c-1][131] = 1'b0;
      h_op[c-1][131] = 1'b0;
    end
    h_ep[c] = ep;
    h_op[c] = op;
    finalize(c - 1);
    @(negedge clock);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  task automatic set_q(input int e0, input int e1, input int e2, input int o0, input int o1);
    bif.ep_q_addr[0] = 7'(e0);
    bif.ep_q_addr[1] = 7'(e1);
    bif.ep_q_addr[2] = 7'(e2);
    bif.op_q_addr[0] = 7'(o0);
    bif.op_q_addr[1] = 7'(o1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_ep"}, 143'(bif.wrt_back_arr_ep), '0);
    chk({tag, "_wb_op"}, 143'(bif.wrt_back_arr_op), '0);
    for (int q = 0; q < NQ_EP; q++)
      chk($sformatf("%s_ep_fwd%0d", tag, q),
          143'({bif.ep_q_hit[q], bif.ep_q_haz[q], bif.ep_q_val[q]}), '0);
    for (int q = 0; q < NQ_OP; q++)
      chk($sformatf("%s_op_fwd%0d", tag, q),
          143'({bif.op_q_hit[q], bif.op_q_haz[q], bif.op_q_val[q]}), '0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NH; i++) begin
      h_ep[i] = '0;
      h_op[i] = '0;
    end
    sb.delete();
  endtask

  // Monitor: pops the scoreboard entry due at this edge (none means idle bus).
  initial begin
    exp_t         e;
    logic         mh, mz;
    logic [127:0] mv;
    forever begin
      @(posedge clock);
      ecnt++;
      #1;
      e.edge_n = ecnt; e.ep = '0; e.op = '0;
      if (sb.size() > 0 && sb[0].edge_n == ecnt) e = sb.pop_front();
      chk("wb_ep", 143'(bif.wrt_back_arr_ep), 143'(e.ep));
      chk("wb_op", 143'(bif.wrt_back_arr_op), 143'(e.op));
      for (int q = 0; q < NQ_EP; q++) begin
        model_fwd(bif.ep_q_addr[q], mh, mz, mv);
        chk($sformatf("ep_fwd%0d", q),
            143'({bif.ep_q_hit[q], bif.ep_q_haz[q], bif.ep_q_val[q]}), 143'({mh, mz, mv}));
      end
      for (int q = 0; q < NQ_OP; q++) begin
        model_fwd(bif.op_q_addr[q], mh, mz, mv);
        chk($sformatf("op_fwd%0d", q),
            143'({bif.op_q_hit[q], bif.op_q_haz[q], bif.op_q_val[q]}), 143'({mh, mz, mv}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    clear_model();
    bif.ep_in = '0; bif.op_in = '0; bif.flush = 1'b0;
    set_q(5, 9, 12, 4, 6);
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Retire timing and readiness on RT 5
    step(mk(1, 5, a5, 2), '0, 1'b0); zeros(9);
    step(mk(1, 5, a5, 4), '0, 1'b0); zeros(9);
    // Newest wins on RT 9
    step(mk(1, 9, 128'd1, 1), '0, 1'b0);
    step(mk(1, 9, 128'd2, 6), '0, 1'b0); zeros(9);
    // Same-RT collision at retire
    step(mk(1, 12, 128'h11, 1), mk(1, 12, 128'h22, 1), 1'b0); zeros(9);
    // Flush: A survives, B (stage 1) and C (input) are killed
    set_q(3, 4, 6, 4, 6);
    step(mk(1, 3, 128'hA, 1), '0, 1'b0);
    step('0, mk(1, 4, 128'hB, 1), 1'b0);
    step(mk(1, 6, 128'hC, 1), '0, 1'b1); zeros(9);
    // Latency extremes and address 0
    set_q(0, 1, 2, 0, 1);
    step(mk(1, 0, 128'h5, 0), mk(1, 1, 128'h6, 15), 1'b0); zeros(9);

    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0)
        set_q($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
      step(rnd_pkt(), rnd_pkt(), $urandom_range(0, 9) == 0);
    end

    // Mid-cycle async reset with packets in flight
    set_q(1, 2, 3, 4, 5);
    step(mk(1, 1, 128'h71, 1), mk(1, 4, 128'h74, 1), 1'b0);
    step(mk(1, 2, 128'h72, 1), mk(1, 5, 128'h75, 1), 1'b0);
    step(mk(1, 3, 128'h73, 1), '0, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    bif.ep_in = '0; bif.op_in = '0; bif.flush = 1'b0;
    #1;
    chk_all_zero("async_rst");
    clear_model();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(mk(1, 2, 128'h99, 3), '0, 1'b0); zeros(9);

    for (int i = 0; i < 150; i++) begin
      if (i % 4 == 0)
        set_q($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
      step(rnd_pkt(), rnd_pkt(), $urandom_range(0, 7) == 0);
    end
    zeros(10);
    repeat (DEPTH + 2) @(negedge clock);
    chk("sb_drain", 143'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
